// File: rtl/agc_gate_pkg.sv
// Shared constants, state encoding and the edit-location write transform
// for the central-register gate sequencer.
package agc_gate_pkg;

  // Offsets of the editing locations above the plain register block.
  localparam int EDIT_CYR  = 0;
  localparam int EDIT_SR   = 1;
  localparam int EDIT_CYL  = 2;
  localparam int EDIT_EDOP = 3;
  localparam int EDIT_NUM  = 4;

  // Working width of the transform; register words up to this width are supported.
  localparam int XFORM_W    = 64;
  localparam int EDOP_SHIFT = 7;

  // Transaction state; the timepulse counter runs alongside ST_BUSY.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int TP_IDLE = 0;

  // Transform applied to data written into an editing location, for a word of w bits.
  function automatic logic [XFORM_W-1:0] edit_xform(input logic [1:0] mode,
                                                    input logic [XFORM_W-1:0] d,
                                                    input int w);
    logic [XFORM_W-1:0] mask;
    logic [XFORM_W-1:0] dm;
    logic [XFORM_W-1:0] res;
    mask = (w >= XFORM_W) ? '1 : ((XFORM_W'(1) << w) - XFORM_W'(1));
    dm   = d & mask;
    case (mode)
      2'(EDIT_CYR): res = (dm >> 1) | ((dm & XFORM_W'(1)) << (w - 1));
      2'(EDIT_SR):  res = (dm >> 1) | (dm & (XFORM_W'(1) << (w - 1)));
      2'(EDIT_CYL): res = (dm << 1) | (dm >> (w - 1));
      default:      res = dm >> EDOP_SHIFT;
    endcase
    return res & mask;
  endfunction

endpackage

// File: rtl/agc_gate_decoder.sv
// Registered address decoder: one-hot select over the plain and editing
// locations plus a flag for addresses beyond the editing block.
module agc_gate_decoder
  import agc_gate_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int ADDRW = 5
) (
  input  logic             CLOCK,
  input  logic             rst,
  input  logic             load,
  input  logic [ADDRW-1:0] addr,
  output logic [NREG+3:0]  sel,
  output logic             ill
);

  localparam int NSEL = NREG + EDIT_NUM;

  // Capture the decode when a transaction is accepted; hold it for the whole sequence.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      sel <= '0;
      ill <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < NSEL; i++) begin
        sel[i] <= (int'(addr) == i);
      end
      ill <= (int'(addr) >= NSEL);
    end
  end

endmodule

// File: rtl/agc_gate_sequencer.sv
// Central-register gate sequencer: one transaction per NTP+1 cycles, one-hot
// active-low read/write gates on fixed timepulses, built-in register storage
// with transformed writes into the editing locations.
module agc_gate_sequencer
  import agc_gate_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int NTP   = 12,
  parameter int ADDRW = 5
) (
  input  logic                     CLOCK,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wr,
  input  logic [ADDRW-1:0]         req_addr,
  input  logic [WIDTH-1:0]         req_wdata,
  input  logic                     ginh,
  output logic [NREG+3:0]          rgate_,
  output logic [NREG+3:0]          wgate_,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     err,
  output logic [$clog2(NTP+1)-1:0] tp
);

  localparam int NSEL = NREG + EDIT_NUM;
  localparam int TPW  = $clog2(NTP + 1);
  localparam int ZREG = NREG - 1;

  state_t               state, state_nxt;
  logic [TPW-1:0]       tp_q, tp_nxt;
  logic                 accept;
  logic                 wr_p0;
  logic [ADDRW-1:0]     addr_p0;
  logic [WIDTH-1:0]     wdata_p0;
  logic [NSEL-1:0]      sel;
  logic                 ill;
  logic [WIDTH-1:0]     mem [NSEL];
  logic [WIDTH-1:0]     rd_word;
  logic [WIDTH-1:0]     store_word;
  logic                 is_edit;
  logic [1:0]           edit_mode;
  logic [XFORM_W-1:0]   xf;
  logic                 rwin, wwin, rd_strobe, commit;

  assign req_ready = (state == ST_IDLE);
  assign tp        = tp_q;
  assign err       = ill && (tp_q == TPW'(1));

  // State and timepulse register.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      tp_q  <= TPW'(TP_IDLE);
    end else begin
      state <= state_nxt;
      tp_q  <= tp_nxt;
    end
  end

  // Next state, timepulse advance and the gate/strobe windows keyed on the upcoming timepulse.
  always_comb begin
    state_nxt = state;
    tp_nxt    = tp_q;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = ST_BUSY;
          tp_nxt    = TPW'(1);
        end
      end
      ST_BUSY: begin
        if (tp_q == TPW'(NTP)) begin
          state_nxt = ST_IDLE;
          tp_nxt    = TPW'(TP_IDLE);
        end else begin
          tp_nxt = tp_q + TPW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tp_nxt    = TPW'(TP_IDLE);
      end
    endcase
    rwin      = !wr_p0 && ((tp_nxt == TPW'(2)) || (tp_nxt == TPW'(3)));
    wwin      = wr_p0 && ((tp_nxt == TPW'(NTP - 2)) || (tp_nxt == TPW'(NTP - 1)));
    rd_strobe = !wr_p0 && (tp_nxt == TPW'(4));
    commit    = wr_p0 && (tp_q == TPW'(NTP - 1)) && !ginh;
  end

  // Transaction direction, captured at accept.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      wr_p0 <= 1'b0;
    end else if (accept) begin
      wr_p0 <= req_wr;
    end
  end

  // Transaction address and data, captured at accept.
  always_ff @(posedge CLOCK) begin
    if (accept) begin
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  agc_gate_decoder #(
    .NREG  (NREG),
    .ADDRW (ADDRW)
  ) u_decoder (
    .CLOCK (CLOCK),
    .rst   (rst),
    .load  (accept),
    .addr  (req_addr),
    .sel   (sel),
    .ill   (ill)
  );

  // Write data after the editing-location transform.
  always_comb begin
    is_edit    = (int'(addr_p0) >= NREG);
    edit_mode  = 2'(addr_p0 - ADDRW'(NREG));
    xf         = edit_xform(edit_mode, XFORM_W'(wdata_p0), WIDTH);
    store_word = is_edit ? xf[WIDTH-1:0] : wdata_p0;
  end

  // Read mux over the one-hot select; the zero register and illegal addresses read as 0.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NSEL; i++) begin
      if (sel[i] && (i != ZREG)) begin
        rd_word = rd_word | mem[i];
      end
    end
  end

  // Register storage; the commit edge is the one ending TP(NTP-1).
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSEL; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < NSEL; i++) begin
        if (sel[i] && (i != ZREG)) begin
          mem[i] <= store_word;
        end
      end
    end
  end

  // Registered gates and read result.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      rgate_   <= '1;
      wgate_   <= '1;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rgate_   <= rwin ? ~sel : '1;
      wgate_   <= wwin ? ~sel : '1;
      rd_valid <= rd_strobe;
      if (rd_strobe) begin
        rd_data <= rd_word;
      end
    end
  end

endmodule
